// File: rtl/fb_pkg.sv
// Shared types and address-split helpers
// for the banked VGA frame buffer.
package fb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  function automatic logic [31:0] bank_idx(
    input logic [31:0] addr,
    input int unsigned loc_w
  );
    return addr >> loc_w;
  endfunction

  function automatic logic [31:0] local_addr(
    input logic [31:0] addr,
    input int unsigned loc_w
  );
    return addr & ((32'd1 << loc_w) - 32'd1);
  endfunction

endpackage

// File: rtl/fb_bank.sv
// Simple dual-port RAM bank: port A read/write,
// port B read-only, both with synchronous read.
module fb_bank #(
  parameter int unsigned WORDS = 65536,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          a_en_i,
  input  logic          a_we_i,
  input  logic [AW-1:0] a_addr_i,
  input  logic [DW-1:0] a_wdata_i,
  output logic [DW-1:0] a_rdata_o,
  input  logic          b_en_i,
  input  logic [AW-1:0] b_addr_i,
  output logic [DW-1:0] b_rdata_o
);

  logic [DW-1:0] mem [WORDS];

  // Both reads sample the array before the
  // write lands, so collisions see old data.
  always_ff @(posedge clk) begin
    if (a_we_i) begin
      mem[a_addr_i] <= a_wdata_i;
    end
    if (a_en_i) begin
      a_rdata_o <= mem[a_addr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (b_en_i) begin
      b_rdata_o <= mem[b_addr_i];
    end
  end

endmodule

// File: rtl/banked_frame_buffer.sv
// Banked frame buffer: host port, raster pixel
// port and a hardware clear engine.
module banked_frame_buffer
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned BANK_WORDS = 65536,
  localparam int unsigned NPIX      = WIDTH * HEIGHT,
  localparam int unsigned ADDR_W    = $clog2(NPIX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              draw_en,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  output logic [PIX_W-1:0]  pixel,
  output logic              pixel_valid,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [PIX_W-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [PIX_W-1:0]  rsp_rdata,
  output logic              err,
  input  logic              clear_start,
  input  logic [PIX_W-1:0]  clear_value,
  output logic              busy,
  output logic              clear_done
);

  localparam int unsigned LOC_W =
    $clog2(BANK_WORDS);
  localparam int unsigned NBANKS =
    (NPIX + BANK_WORDS - 1) / BANK_WORDS;
  localparam int unsigned HB_W =
    (ADDR_W > LOC_W) ? ADDR_W - LOC_W : 1;
  localparam logic [LOC_W-1:0] LAST =
    LOC_W'(BANK_WORDS - 1);
  localparam logic [LOC_W-1:0] PENULT =
    LOC_W'(BANK_WORDS - 2);

  state_e             state_q;
  logic [LOC_W-1:0]   cnt_q;
  logic [PIX_W-1:0]   clr_val_q;
  logic               busy_q;
  logic               done_q;

  logic               acc;
  logic               h_oob;
  logic               h_wr;
  logic               h_rd;
  logic               clearing;
  logic               pix_en;
  logic [ADDR_W:0]    pix_lin;
  logic [HB_W-1:0]    h_bank;
  logic [HB_W-1:0]    p_bank;
  logic [LOC_W-1:0]   h_loc;
  logic [LOC_W-1:0]   p_loc;
  logic [LOC_W-1:0]   a_addr;
  logic [PIX_W-1:0]   a_wdata;
  logic [NBANKS-1:0]  a_we;
  logic [NBANKS-1:0]  a_en;
  logic [NBANKS-1:0]  b_en;
  logic [PIX_W-1:0]   a_rd [NBANKS];
  logic [PIX_W-1:0]   b_rd [NBANKS];
  logic [PIX_W-1:0]   h_mux;
  logic [PIX_W-1:0]   p_mux;

  logic               h_rd1_q;
  logic               h_oob1_q;
  logic [HB_W-1:0]    h_bank1_q;
  logic               p_val1_q;
  logic [HB_W-1:0]    p_bank1_q;
  logic               rsp_valid_q;
  logic [PIX_W-1:0]   rsp_rdata_q;
  logic               err_q;
  logic [PIX_W-1:0]   pixel_q;
  logic               pixel_valid_q;

  assign req_ready = (state_q == IDLE);
  assign acc   = req_valid && req_ready && rst_n;
  assign h_oob = 32'(req_addr) >= NPIX;
  assign h_wr  = acc && req_we && !h_oob;
  assign h_rd  = acc && !req_we && !h_oob;

  // Gated by reset so an aborted fill stops
  // writing on the reset edge itself.
  assign clearing = (state_q == CLEAR) && rst_n;

  assign h_bank =
    HB_W'(bank_idx(32'(req_addr), LOC_W));
  assign h_loc =
    LOC_W'(local_addr(32'(req_addr), LOC_W));

  assign pix_en = draw_en
    && (32'(hcount) < WIDTH)
    && (32'(vcount) < HEIGHT);

  assign pix_lin =
    (ADDR_W+1)'(vcount) * (ADDR_W+1)'(WIDTH)
    + (ADDR_W+1)'(hcount);

  assign p_bank =
    HB_W'(bank_idx(32'(pix_lin), LOC_W));
  assign p_loc =
    LOC_W'(local_addr(32'(pix_lin), LOC_W));

  assign a_addr  = clearing ? cnt_q : h_loc;
  assign a_wdata = clearing ? clr_val_q
                            : req_wdata;

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    assign a_we[b] = clearing
      || (h_wr && (h_bank == HB_W'(b)));
    assign a_en[b] = h_rd
      && (h_bank == HB_W'(b));
    assign b_en[b] = pix_en
      && (p_bank == HB_W'(b));

    fb_bank #(
      .WORDS (BANK_WORDS),
      .DW    (PIX_W),
      .AW    (LOC_W)
    ) u_bank (
      .clk       (clk),
      .a_en_i    (a_en[b]),
      .a_we_i    (a_we[b]),
      .a_addr_i  (a_addr),
      .a_wdata_i (a_wdata),
      .a_rdata_o (a_rd[b]),
      .b_en_i    (b_en[b]),
      .b_addr_i  (p_loc),
      .b_rdata_o (b_rd[b])
    );
  end

  always_comb begin
    h_mux = '0;
    p_mux = '0;
    for (int unsigned b = 0; b < NBANKS; b++) begin
      if (h_bank1_q == HB_W'(b)) begin
        h_mux = a_rd[b];
      end
      if (p_bank1_q == HB_W'(b)) begin
        p_mux = b_rd[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clr_val_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (clear_start && !acc) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            clr_val_q <= clear_value;
            busy_q    <= 1'b1;
            done_q    <= (LAST == '0);
          end
        end
        CLEAR: begin
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            done_q <= (cnt_q == PENULT);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1 rides alongside the RAM read,
  // stage 2 is the registered bank mux.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_rd1_q       <= 1'b0;
      h_oob1_q      <= 1'b0;
      h_bank1_q     <= '0;
      p_val1_q      <= 1'b0;
      p_bank1_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      err_q         <= 1'b0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      h_rd1_q     <= acc && !req_we;
      h_oob1_q    <= acc && h_oob;
      h_bank1_q   <= h_bank;
      p_val1_q    <= pix_en;
      p_bank1_q   <= p_bank;
      rsp_valid_q <= h_rd1_q;
      rsp_rdata_q <= (h_rd1_q && !h_oob1_q)
                     ? h_mux : '0;
      err_q       <= h_oob1_q;
      pixel_q     <= p_val1_q ? p_mux : '0;
      pixel_valid_q <= p_val1_q;
    end
  end

  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign clear_done  = done_q;

endmodule

// File: tb/tb_banked_frame_buffer.sv
// Directed-vector bench for banked_frame_buffer
// at the default 640x480, 5-bank geometry.
module tb_banked_frame_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        draw_en = 1'b0;
  logic [9:0]  hcount = '0;
  logic [9:0]  vcount = '0;
  logic [7:0]  pixel;
  logic        pixel_valid;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [18:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        err;
  logic        clear_start = 1'b0;
  logic [7:0]  clear_value = '0;
  logic        busy;
  logic        clear_done;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  banked_frame_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .draw_en     (draw_en),
    .hcount      (hcount),
    .vcount      (vcount),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .err         (err),
    .clear_start (clear_start),
    .clear_value (clear_value),
    .busy        (busy),
    .clear_done  (clear_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic wr(
    input logic [18:0] a,
    input logic [7:0]  d
  );
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = a;
    req_wdata = d;
    tick;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic rd(
    input  logic [18:0] a,
    output logic        v,
    output logic [7:0]  d,
    output logic        e
  );
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    tick;
    req_valid = 1'b0;
    tick;
    v = rsp_valid;
    d = rsp_rdata;
    e = err;
  endtask

  task automatic pix(
    input  logic [9:0] h,
    input  logic [9:0] v,
    output logic       pv,
    output logic [7:0] pd
  );
    draw_en = 1'b1;
    hcount  = h;
    vcount  = v;
    tick;
    draw_en = 1'b0;
    tick;
    pv = pixel_valid;
    pd = pixel;
  endtask

  initial begin
    logic       v;
    logic       e;
    logic [7:0] d;
    int n;
    int dn;
    int dat;
    int viol;

    repeat (3) tick;
    check("rst rsp_valid", 32'(rsp_valid), 0);
    check("rst rsp_rdata", 32'(rsp_rdata), 0);
    check("rst err", 32'(err), 0);
    check("rst busy", 32'(busy), 0);
    check("rst clear_done", 32'(clear_done), 0);
    check("rst pixel", 32'(pixel), 0);
    check("rst pixel_valid", 32'(pixel_valid), 0);
    check("rst req_ready", 32'(req_ready), 1);
    rst_n = 1'b1;
    tick;

    // Bank isolation around a bank-1 write
    wr(19'd0,      8'h10);
    wr(19'd131072, 8'h12);
    wr(19'd196608, 8'h13);
    wr(19'd262144, 8'h14);
    wr(19'd65536,  8'h5B);
    wr(19'd65536,  8'hA5);
    rd(19'd65536, v, d, e);
    check("b1 rsp_valid", 32'(v), 1);
    check("b1 rdata", 32'(d), 32'h A5);
    check("b1 err", 32'(e), 0);
    tick;
    check("rsp pulse", 32'(rsp_valid), 0);
    rd(19'd0, v, d, e);
    check("b0 rdata", 32'(d), 32'h10);
    rd(19'd131072, v, d, e);
    check("b2 rdata", 32'(d), 32'h12);
    rd(19'd196608, v, d, e);
    check("b3 rdata", 32'(d), 32'h13);
    rd(19'd262144, v, d, e);
    check("b4 rdata", 32'(d), 32'h14);

    // Back-to-back reads, one per cycle
    req_valid = 1'b1;
    req_addr  = 19'd0;
    tick;
    req_addr = 19'd65536;
    tick;
    check("b2b0 valid", 32'(rsp_valid), 1);
    check("b2b0 rdata", 32'(rsp_rdata), 32'h10);
    req_addr = 19'd131072;
    tick;
    check("b2b1 rdata", 32'(rsp_rdata), 32'h A5);
    req_valid = 1'b0;
    tick;
    check("b2b2 rdata", 32'(rsp_rdata), 32'h12);
    tick;

    // Pixel port: 103*640+0 = 65920
    wr(19'd65920, 8'h3C);
    pix(10'd0, 10'd103, v, d);
    check("pix valid", 32'(v), 1);
    check("pix data", 32'(d), 32'h3C);
    pix(10'd640, 10'd0, v, d);
    check("pix h oor valid", 32'(v), 0);
    check("pix h oor data", 32'(d), 0);
    pix(10'd0, 10'd480, v, d);
    check("pix v oor valid", 32'(v), 0);
    hcount = 10'd0;
    vcount = 10'd103;
    tick;
    tick;
    check("pix no draw", 32'(pixel_valid), 0);

    // Out-of-range host accesses
    wr(19'd307199, 8'h66);
    tick;
    check("wr ok err", 32'(err), 0);
    wr(19'd307200, 8'h99);
    tick;
    check("wr oor err", 32'(err), 1);
    tick;
    check("err pulse", 32'(err), 0);
    rd(19'd307199, v, d, e);
    check("last word", 32'(d), 32'h66);
    rd(19'd307200, v, d, e);
    check("rd oor valid", 32'(v), 1);
    check("rd oor rdata", 32'(d), 0);
    check("rd oor err", 32'(e), 1);

    // Collision: pixel sees old data
    wr(19'd5, 8'h22);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 19'd5;
    req_wdata = 8'h11;
    draw_en   = 1'b1;
    hcount    = 10'd5;
    vcount    = 10'd0;
    tick;
    req_valid = 1'b0;
    req_we    = 1'b0;
    tick;
    check("coll old", 32'(pixel), 32'h22);
    draw_en = 1'b0;
    tick;
    check("coll new", 32'(pixel), 32'h11);

    // Full clear
    clear_value = 8'hFF;
    clear_start = 1'b1;
    tick;
    clear_start = 1'b0;
    clear_value = 8'h00;
    n = 0;
    dn = 0;
    dat = -1;
    viol = 0;
    while (busy === 1'b1 && n < 70000) begin
      if (req_ready) viol++;
      if (clear_done) begin
        dn++;
        dat = n;
      end
      n++;
      tick;
    end
    check("clr busy cycles", 32'(n), 65536);
    check("clr done count", 32'(dn), 1);
    check("clr done cycle", 32'(dat), 65535);
    check("clr ready low", 32'(viol), 0);
    check("clr ready back", 32'(req_ready), 1);
    rd(19'd0, v, d, e);
    check("clr word0", 32'(d), 32'hFF);
    rd(19'd307199, v, d, e);
    check("clr last", 32'(d), 32'hFF);
    rd(19'd65920, v, d, e);
    check("clr b1", 32'(d), 32'hFF);

    // Host wins over clear_start, then reset aborts
    wr(19'd200, 8'h77);
    req_valid   = 1'b1;
    req_addr    = 19'd200;
    clear_start = 1'b1;
    clear_value = 8'h5A;
    tick;
    check("prio busy", 32'(busy), 0);
    req_valid = 1'b0;
    tick;
    clear_start = 1'b0;
    check("prio start", 32'(busy), 1);
    check("prio rsp", 32'(rsp_valid), 1);
    check("prio rdata", 32'(rsp_rdata), 32'h77);
    repeat (100) tick;
    check("abort pre busy", 32'(busy), 1);
    rst_n = 1'b0;
    tick;
    check("abort busy", 32'(busy), 0);
    check("abort ready", 32'(req_ready), 1);
    check("abort done", 32'(clear_done), 0);
    rst_n = 1'b1;
    tick;
    rd(19'd0, v, d, e);
    check("abort w0", 32'(d), 32'h5A);
    rd(19'd99, v, d, e);
    check("abort w99", 32'(d), 32'h5A);
    rd(19'd200, v, d, e);
    check("abort w200", 32'(d), 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
